// File: rtl/bpred_btb_if.sv
// Fetch lookup, EX training and perf-counter signals of the branch target buffer.
interface bpred_btb_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned PERF_W = 16
);
    logic [ADDR_W-1:0] if_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_is_jump;
    logic              upd_mispred;
    logic              inv_all;
    logic [PERF_W-1:0] mispred_cnt;

    // Pipeline side: issues lookups and training, observes predictions.
    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_is_jump, upd_mispred, inv_all,
        input  pred_taken, pred_target, mispred_cnt
    );

    // BTB side.
    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_is_jump, upd_mispred, inv_all,
        output pred_taken, pred_target, mispred_cnt
    );
endinterface

// File: rtl/bpred_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters and a saturating mispredict counter. Lookup is combinational;
// training lands at the clock edge with no bypass to the same-cycle lookup.
module bpred_btb #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned PERF_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    bpred_btb_if.slave    bus
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_WEAK_T = CNT_W'(1) << (CNT_W - 1);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];
    logic [PERF_W-1:0]  mispred_q;

    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;

    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;
    logic               cnt_we;
    logic [CNT_W-1:0]   cnt_d;
    logic               tgt_we;
    logic               alloc;

    logic               unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.if_pc[1:0], bus.upd_pc[1:0]};

    // Fetch-side lookup against the current (pre-update) table contents.
    always_comb begin
        lk_idx          = bus.if_pc[IDX_W+1:2];
        lk_tag          = bus.if_pc[ADDR_W-1:IDX_W+2];
        lk_hit          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        bus.pred_taken  = lk_hit && cnt_q[lk_idx][CNT_W-1];
        bus.pred_target = bus.pred_taken ? target_q[lk_idx] : '0;
    end

    assign bus.mispred_cnt = mispred_q;

    // Training decision; a same-cycle invalidate suppresses it entirely.
    always_comb begin
        up_idx = bus.upd_pc[IDX_W+1:2];
        up_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];
        up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        cnt_we = 1'b0;
        cnt_d  = cnt_q[up_idx];
        tgt_we = 1'b0;
        alloc  = 1'b0;
        if (bus.upd_valid && !bus.inv_all) begin
            if (up_hit) begin
                cnt_we = 1'b1;
                if (bus.upd_is_jump) begin
                    cnt_d  = '1;
                    tgt_we = 1'b1;
                end else if (bus.upd_taken) begin
                    cnt_d  = (cnt_q[up_idx] == '1) ? cnt_q[up_idx] : cnt_q[up_idx] + CNT_W'(1);
                    tgt_we = 1'b1;
                end else begin
                    cnt_d  = (cnt_q[up_idx] == '0) ? cnt_q[up_idx] : cnt_q[up_idx] - CNT_W'(1);
                end
            end else if (bus.upd_taken) begin
                alloc  = 1'b1;
                cnt_we = 1'b1;
                tgt_we = 1'b1;
                cnt_d  = bus.upd_is_jump ? '1 : CNT_WEAK_T;
            end
        end
    end

    // Valid bits, direction counters and mispredict counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            mispred_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (bus.inv_all) begin
                valid_q <= '0;
            end else if (alloc) begin
                valid_q[up_idx] <= 1'b1;
            end
            if (cnt_we) begin
                cnt_q[up_idx] <= cnt_d;
            end
            if (bus.upd_valid && bus.upd_mispred && (mispred_q != '1)) begin
                mispred_q <= mispred_q + PERF_W'(1);
            end
        end
    end

    // Tag and target storage; contents are don't-care while the entry is invalid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (alloc) begin
                tag_q[up_idx] <= up_tag;
            end
            if (tgt_we) begin
                target_q[up_idx] <= bus.upd_target;
            end
        end
    end
endmodule
